// File: rtl/polyvec_acc_if.sv
// Handshake bundle for polyvec_acc_montgomery: coefficient-pair input stream
// and accumulated-coefficient output stream.
interface polyvec_acc_if #(
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/polyvec_acc_montgomery.sv
// Coefficient-serial Montgomery multiply-accumulate over L polynomials, then drains N results.
// Optional macro POLYVEC_ACC_REDUCE32_EN applies reduce32 to each output coefficient.
module polyvec_acc_montgomery #(
  parameter int L    = 4,
  parameter int N    = 256,
  parameter int Q    = 8380417,
  parameter int QINV = 58728449
) (
  input  logic         clk,
  input  logic         rst,
  polyvec_acc_if.slave bus,
  output logic         busy
);
  localparam int DATA_W = 32;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam logic signed [63:0]       Q64       = 64'(Q);
  localparam logic signed [DATA_W-1:0] Q32       = 32'(Q);
  localparam logic [31:0]              QINV32    = 32'(QINV);
  localparam logic [CW-1:0]            COEF_LAST = CW'(N - 1);
  localparam logic [PW-1:0]            POLY_LAST = PW'(L - 1);

  typedef enum logic [1:0] {ACC, FLUSH, DRAIN} state_t;

  // t = (p - sext32(p*QINV mod 2^32)*Q) >>> 32; low 32 bits of the difference are zero
  function automatic logic signed [DATA_W-1:0] mont_reduce(input logic signed [63:0] p);
    logic [31:0]        lo;
    logic signed [63:0] m;
    logic signed [63:0] d;
    lo = p[31:0] * QINV32;
    m  = {{32{lo[31]}}, lo};
    d  = p - m * Q64;
    return d[63:32];
  endfunction

`ifdef POLYVEC_ACC_REDUCE32_EN
  function automatic logic signed [DATA_W-1:0] reduce32(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] k;
    k = (x + 32'sd4194304) >>> 23;
    return x - k * Q32;
  endfunction
`endif

  function automatic logic signed [DATA_W-1:0] out_map(input logic signed [DATA_W-1:0] x);
`ifdef POLYVEC_ACC_REDUCE32_EN
    return reduce32(x);
`else
    return x;
`endif
  endfunction

  state_t                   state_q, state_d;
  logic [CW-1:0]            coef_idx;
  logic [PW-1:0]            poly_idx;
  logic [CW-1:0]            out_idx;
  logic                     hs_in;
  logic                     last_in;
  logic                     hs_out;

  logic signed [63:0]       a_ext, b_ext;
  logic signed [63:0]       prod_p0;
  logic [CW-1:0]            idx_p0, idx_p1;
  logic                     first_p0, first_p1;
  logic                     vld_p0, vld_p1;
  logic signed [DATA_W-1:0] t_p1;
  logic signed [DATA_W-1:0] acc_mem [N];

  logic                     out_valid_q, out_last_q;
  logic signed [DATA_W-1:0] out_data_q;

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

  assign hs_in   = bus.in_valid && (state_q == ACC);
  assign last_in = (coef_idx == COEF_LAST) && (poly_idx == POLY_LAST);
  assign hs_out  = out_valid_q && bus.out_ready;
  assign busy    = (state_q != ACC) || (coef_idx != '0) || (poly_idx != '0);

  assign a_ext = {{32{bus.in_a[DATA_W-1]}}, bus.in_a};
  assign b_ext = {{32{bus.in_b[DATA_W-1]}}, bus.in_b};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (hs_in && last_in) state_d = FLUSH;
      // Leave once S1 is empty: the S2 entry still in flight lands in RAM on this edge
      FLUSH:   if (!vld_p0) state_d = DRAIN;
      DRAIN:   if (hs_out && out_last_q) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_idx <= '0;
      poly_idx <= '0;
    end else if (hs_in) begin
      if (coef_idx == COEF_LAST) begin
        coef_idx <= '0;
        poly_idx <= (poly_idx == POLY_LAST) ? '0 : poly_idx + 1'b1;
      end else begin
        coef_idx <= coef_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= hs_in;
      vld_p1 <= vld_p0;
    end
  end

  // S1: signed 64-bit product
  always_ff @(posedge clk) begin
    prod_p0  <= a_ext * b_ext;
    idx_p0   <= coef_idx;
    first_p0 <= (poly_idx == '0);
  end

  // S2: Montgomery reduction
  always_ff @(posedge clk) begin
    t_p1     <= mont_reduce(prod_p0);
    idx_p1   <= idx_p0;
    first_p1 <= first_p0;
  end

  // S3: accumulator write; same-index accesses are N cycles apart so no forwarding is needed
  always_ff @(posedge clk) begin
    if (vld_p1)
      acc_mem[idx_p1] <= first_p1 ? t_p1 : acc_mem[idx_p1] + t_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_idx     <= '0;
    end else if (state_q == DRAIN) begin
      if (hs_out && out_last_q) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        out_idx     <= '0;
      end else if (!out_valid_q || bus.out_ready) begin
        out_data_q  <= out_map(acc_mem[out_idx]);
        out_valid_q <= 1'b1;
        out_last_q  <= (out_idx == COEF_LAST);
        out_idx     <= out_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_polyvec_acc_montgomery.sv
// Self-checking bench for polyvec_acc_montgomery: constant-vector table, random
// vectors against an arithmetic model, backpressure, reset abort and back-to-back runs.
module tb_polyvec_acc_montgomery;
  localparam int L    = 4;
  localparam int N    = 256;
  localparam int Q    = 8380417;
  localparam int QINV = 58728449;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int va [N*L];
  int vb [N*L];
  int exp_q [N];

  polyvec_acc_if #(.DATA_W(32)) bus ();

  polyvec_acc_montgomery #(.L(L), .N(N), .Q(Q), .QINV(QINV)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    a0, b0, ar, br;
    int    exp_raw, exp_red;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Montgomery product a*b*2^-32 mod Q as the exact quotient of a multiple of 2^32
  function automatic int mont_model(input int a, input int b);
    longint p, m, d;
    p = longint'(a) * longint'(b);
    m = longint'(int'(p * longint'(QINV)));
    d = p - m * longint'(Q);
    return int'(d / 64'sd4294967296);
  endfunction

  function automatic int reduce_model(input int x);
    longint k, qd;
    k  = longint'(x) + 4194304;
    qd = k / 8388608;
    if (k < 0 && (k % 8388608) != 0) qd = qd - 1;
    return int'(longint'(x) - qd * longint'(Q));
  endfunction

  function automatic void model_expected();
    for (int i = 0; i < N; i++) begin
      longint s = 0;
      for (int j = 0; j < L; j++) s += mont_model(va[j*N+i], vb[j*N+i]);
`ifdef POLYVEC_ACC_REDUCE32_EN
      exp_q[i] = reduce_model(int'(s));
`else
      exp_q[i] = int'(s);
`endif
    end
  endfunction

  function automatic void fill_const(input int a0, input int b0, input int ar, input int br);
    for (int k = 0; k < N*L; k++) begin
      va[k] = (k < N) ? a0 : ar;
      vb[k] = (k < N) ? b0 : br;
    end
  endfunction

  task automatic send_vector(input int count, input bit hold_valid, output int t_last);
    t_last = -1;
    for (int k = 0; k < count; k++) begin
      int guard = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = va[k];
      bus.in_b     = vb[k];
      while (!bus.in_ready && guard < 2000) begin
        step();
        guard++;
      end
      if (guard >= 2000) begin
        check("in_ready_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      t_last = cyc;
      step();
    end
    bus.in_valid = hold_valid;
    bus.in_a     = 32'sh5a5a5a5a;
    bus.in_b     = 32'sh12345678;
  endtask

  task automatic collect(input string tag, input bit rand_ready, input int t_last);
    int k = 0;
    int guard = 0;
    int first_seen = -1;
    int in_viol = 0;
    int last_err = 0;
    check({tag, "_busy_in_flush"}, busy, 1);
    while (k < N && guard < 20000) begin
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.in_valid && bus.in_ready) in_viol++;
      if (bus.out_valid && first_seen < 0) first_seen = cyc;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("%s_out%0d", tag, k), bus.out_data, exp_q[k]);
        if (bus.out_last != (k == N-1)) last_err++;
        k++;
      end
      step();
      guard++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, "_out_count"}, k, N);
    check({tag, "_out_last_pos"}, last_err, 0);
    check({tag, "_no_input_in_drain"}, in_viol, 0);
    check({tag, "_first_valid_latency"}, first_seen - t_last, 4);
    check({tag, "_in_ready_after"}, bus.in_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_out_valid_after"}, bus.out_valid, 0);
  endtask

  vec_t tbl [4];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t_last;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    tbl[0] = '{"ones",  65536,    65536,     65536,    65536,     4,        4};
    tbl[1] = '{"zeros", 0,        0,         0,        0,         0,        0};
    tbl[2] = '{"poly0", 1,        1,         0,        0,         -114592,  -114592};
    tbl[3] = '{"big",   67108864, 268173312, 67108864, 268173312, 16760832, -2};

    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);

    // rows 0 and 1 run back to back: zeros must fully overwrite the previous 4s
    for (int r = 0; r < 4; r++) begin
      fill_const(tbl[r].a0, tbl[r].b0, tbl[r].ar, tbl[r].br);
      for (int i = 0; i < N; i++) begin
`ifdef POLYVEC_ACC_REDUCE32_EN
        exp_q[i] = tbl[r].exp_red;
`else
        exp_q[i] = tbl[r].exp_raw;
`endif
      end
      send_vector(N*L, 1'b0, t_last);
      collect(tbl[r].name, 1'b0, t_last);
    end

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N*L; k++) begin
        va[k] = int'($urandom_range(0, 2*Q - 2)) - (Q - 1);
        vb[k] = int'($urandom_range(0, 2*Q - 2)) - (Q - 1);
      end
      model_expected();
      send_vector(N*L, 1'b1, t_last);
      collect($sformatf("rand%0d", r), 1'b1, t_last);
    end

    fill_const(65536, 65536, 65536, 65536);
    send_vector(2*N + 50, 1'b1, t_last);
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    step();
    check("abort_busy_settled", busy, 0);
    for (int i = 0; i < N; i++) exp_q[i] = 4;
    send_vector(N*L, 1'b0, t_last);
    collect("after_abort", 1'b1, t_last);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
